trace_capture_fifo: RTL and testbench
=====================================

// Module: trace_capture_fifo
// PURPOSE
//  Consumes the per-cycle (selector, x, y) trace that an arithmetic-case top drives.
//  It arms on command and triggers on an x threshold.
//  It then captures cap_len consecutive timestamped samples into a FIFO.
//  Samples drain over a valid/ready stream to the property-mining log sink.
//  It sits beside the case core as the trace reader; it never drives the core.
// PARAMETERS
//  DATA_W  8   width of x and y
//  DEPTH   16  FIFO entries; power of 2, >=2
//  TS_W    16  free-running timestamp width
// PORTS
//  clk       in   1                clock; all logic on posedge
//  rst       in   1                synchronous, active-high reset
//  arm       in   1                request capture; acted on in IDLE or DONE
//  trig_x    in   DATA_W           trigger threshold; live, compared as unsigned
//  cap_len   in   8                samples per capture; sampled at trigger
//  selector  in   1                core selector, sampled every cycle
//  x         in   DATA_W           core output x
//  y         in   DATA_W           core output y
//  out_valid out  1                FIFO head valid
//  out_ready in   1                sink accepts head
//  out_data  out  TS_W+2*DATA_W+1  {ts, selector, x, y} of head entry
//  state     out  2                0=IDLE 1=ARMED 2=CAPTURE 3=DONE
//  drop_cnt  out  8                samples lost to a full FIFO; saturates at 255
//  done      out  1                high while state==DONE
// BEHAVIOUR
//  Reset:
//   - state=IDLE, FIFO empty, out_valid=0, out_data=0, drop_cnt=0, ts=0, done=0.
//   - Reset mid-capture discards all FIFO contents and the remaining count.
//  Timestamp: ts increments every cycle after reset and wraps at 2^TS_W.
//   - A sample's ts is the ts value of the cycle its inputs were sampled.
//  FSM:
//   - IDLE: arm=1 -> ARMED. arm=0 -> stay.
//   - ARMED, x>=trig_x this cycle:
//     - cap_len==0: -> DONE, nothing written.
//     - cap_len==1: this cycle's sample is written, -> DONE.
//     - else: this cycle's sample is written, remaining=cap_len-1, -> CAPTURE.
//   - ARMED, no trigger: stay. arm is ignored.
//   - CAPTURE:
//     - writes one sample every cycle and decrements remaining.
//     - at remaining==1 the write happens and the FSM goes to DONE.
//     - arm is ignored.
//   - DONE: arm=1 -> ARMED and clears drop_cnt. The FIFO is not flushed and keeps draining.
//  FIFO write:
//   - A write is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
//   - Otherwise the sample is dropped and drop_cnt increments, saturating at 255.
//   - A dropped sample still consumes one count of cap_len.
//  FIFO read:
//   - First-word-fall-through. out_valid = !empty. out_data = head entry.
//   - Pop when out_valid && out_ready.
//   - out_data is held stable while out_valid && !out_ready.
//   - out_ready while empty has no effect. out_data keeps its last value (0 after reset).
//  Latency:
//   - A sample written at cycle N into an empty FIFO gives out_valid=1 at N+1.
//   - Push and pop in the same cycle leave the occupancy unchanged.
//  Pointers: wrap modulo DEPTH. Full/empty are distinguished with one extra pointer bit.
// TESTING
//  T1 reset, arm@c2, trig_x=0, cap_len=3, out_ready=1 ->
//     3 entries with consecutive ts, then done=1 and drop_cnt=0.
//  T2 x ramps 0..255, trig_x=10 ->
//     first entry has x=10, its ts equals the trigger cycle, state ARMED->CAPTURE.
//  T3 DEPTH=16, cap_len=20, out_ready=0 -> FIFO full after 16 samples, drop_cnt=4, done=1.
//     Then out_ready=1 -> 16 entries drain in order.
//  T4 FIFO full, out_ready=1 throughout CAPTURE -> no drops (push+pop), drop_cnt=0.
//  T5 cap_len=0 with trigger -> DONE next cycle, out_valid stays 0.
//     arm in DONE -> ARMED, drop_cnt cleared.
//  T6 rst asserted in CAPTURE with 5 queued entries ->
//     next cycle IDLE, out_valid=0, ts=0, drop_cnt=0.
//     Plus 1000 random-selector cycles with out_ready random: every popped entry matches the reference queue.

Source files
------------

// File: rtl/trace_capture_fifo.sv
// Trace reader for the arithmetic-case core. It arms on command and triggers when x reaches trig_x.
// It then captures cap_len timestamped samples into a first-word-fall-through FIFO that drains over valid/ready.
module trace_capture_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic [DATA_W-1:0]        trig_x,
    input  logic [7:0]               cap_len,
    input  logic                     selector,
    input  logic [DATA_W-1:0]        x,
    input  logic [DATA_W-1:0]        y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W+2*DATA_W:0]   out_data,
    output logic [1:0]               state,
    output logic [7:0]               drop_cnt,
    output logic                     done
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OUT_W = TS_W + 2*DATA_W + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAP = 2'd2, S_DONE = 2'd3} state_t;

    state_t             st_q, st_d;
    logic [7:0]         rem_q, rem_d;
    logic [TS_W-1:0]    ts_q;
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [OUT_W-1:0]   mem [DEPTH];
    logic [OUT_W-1:0]   last_q;
    logic               empty, full, pop, push, wr_req, drop, clr_drop;

    // Extra MSB on each pointer separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && out_ready;
    // A full FIFO still takes a sample when the head leaves in the same cycle.
    assign push  = wr_req && (!full || pop);
    assign drop  = wr_req && !push;

    assign out_valid = !empty;
    assign out_data  = empty ? last_q : mem[rd_ptr[AW-1:0]];
    assign state     = st_q;
    assign done      = (st_q == S_DONE);

    always_comb begin
        st_d     = st_q;
        rem_d    = rem_q;
        wr_req   = 1'b0;
        clr_drop = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (arm) st_d = S_ARMED;
            end
            S_ARMED: begin
                if (x >= trig_x) begin
                    if (cap_len == 8'd0) begin
                        st_d = S_DONE;
                    end else begin
                        wr_req = 1'b1;
                        if (cap_len == 8'd1) begin
                            st_d = S_DONE;
                        end else begin
                            rem_d = cap_len - 8'd1;
                            st_d  = S_CAP;
                        end
                    end
                end
            end
            S_CAP: begin
                wr_req = 1'b1;
                if (rem_q == 8'd1) st_d = S_DONE;
                else               rem_d = rem_q - 8'd1;
            end
            S_DONE: begin
                if (arm) begin
                    st_d     = S_ARMED;
                    clr_drop = 1'b1;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= S_IDLE;
            rem_q    <= 8'd0;
            ts_q     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            last_q   <= '0;
            drop_cnt <= 8'd0;
        end else begin
            st_q  <= st_d;
            rem_q <= rem_d;
            ts_q  <= ts_q + TS_W'(1);
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                last_q <= mem[rd_ptr[AW-1:0]];
            end
            if (clr_drop)                      drop_cnt <= 8'd0;
            else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Storage needs no reset; entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {ts_q, selector, x, y};
    end

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Bench for trace_capture_fifo: a queue-level reference model is checked every cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_trace_capture_fifo;
    localparam int DW = 8, DEPTH = 16, TW = 16, OW = TW + 2*DW + 1;

    logic          clk = 1'b0, rst = 1'b1, arm = 1'b0, selector = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] trig_x = '0, x = '0, y = '0;
    logic [7:0]    cap_len = '0;
    logic          out_valid, done;
    logic [OW-1:0] out_data;
    logic [1:0]    state;
    logic [7:0]    drop_cnt;

    trace_capture_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .trig_x(trig_x), .cap_len(cap_len),
        .selector(selector), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .state(state), .drop_cnt(drop_cnt), .done(done)
    );

    always #5 clk = ~clk;

    int  tests = 0, fails = 0;
    bit  cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phases 0..3, a sample queue and the spec's counting rules.
    int            m_state = 0, m_rem = 0, m_drop = 0;
    logic [TW-1:0] m_ts = '0;
    logic [OW-1:0] m_q[$];
    logic [OW-1:0] m_last = '0;
    bit            m_wr;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_rem = 0; m_drop = 0; m_ts = '0; m_last = '0;
            m_q.delete();
        end else begin
            m_wr = 1'b0;
            case (m_state)
                0: if (arm) m_state = 1;
                1: if (x >= trig_x) begin
                       if (cap_len == 0) m_state = 3;
                       else begin
                           m_wr = 1'b1;
                           m_rem = int'(cap_len) - 1;
                           m_state = (m_rem == 0) ? 3 : 2;
                       end
                   end
                2: begin
                       m_wr = 1'b1;
                       m_rem--;
                       if (m_rem == 0) m_state = 3;
                   end
                default: if (arm) begin m_state = 1; m_drop = 0; end
            endcase
            if (m_q.size() > 0 && out_ready) m_last = m_q.pop_front();
            if (m_wr) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_ts, selector, x, y});
                else if (m_drop < 255)  m_drop++;
            end
            m_ts = m_ts + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", 64'(state), 64'(m_state));
            chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            chk("out_data", 64'(out_data), 64'(m_q.size() > 0 ? m_q[0] : m_last));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            chk("done", 64'(done), 64'(m_state == 3));
        end
    end

    // Log of entries actually handed to the sink.
    logic [OW-1:0] pops[$];
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) pops.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; arm = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [OW-1:0] exp_d;

    initial begin
        // T1: short capture with a ready sink
        do_reset();
        cmp_en = 1'b1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        pops.delete();
        trig_x = 8'd0; cap_len = 8'd3; x = 8'd5; y = 8'd7; selector = 1'b1; out_ready = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("t1_armed", 64'(state), 64'd1);
        repeat (5) tick();
        chk("t1_count", 64'(pops.size()), 64'd3);
        exp_d = {16'd1, 1'b1, 8'd5, 8'd7};
        chk("t1_entry0", 64'(pops[0]), 64'(exp_d));
        chk("t1_ts1", 64'(pops[1][32:17]), 64'd2);
        chk("t1_ts2", 64'(pops[2][32:17]), 64'd3);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_drop", 64'(drop_cnt), 64'd0);

        // T2: ramping x, threshold 10
        do_reset();
        out_ready = 1'b0; trig_x = 8'd10; cap_len = 8'd4; selector = 1'b0; x = 8'd0; y = 8'hA5;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int k = 1; k <= 9; k++) begin x = 8'(k); tick(); end
        chk("t2_still_armed", 64'(state), 64'd1);
        chk("t2_empty", 64'(out_valid), 64'd0);
        x = 8'd10; tick();
        chk("t2_capture", 64'(state), 64'd2);
        chk("t2_valid", 64'(out_valid), 64'd1);
        exp_d = {16'd10, 1'b0, 8'd10, 8'hA5};
        chk("t2_head", 64'(out_data), 64'(exp_d));
        for (int k = 11; k <= 13; k++) begin x = 8'(k); tick(); end
        chk("t2_done", 64'(state), 64'd3);

        // T3: overflow with a stalled sink, then drain
        do_reset();
        out_ready = 1'b0; trig_x = 8'd0; cap_len = 8'd20; x = 8'd3; y = 8'd4; selector = 1'b1;
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (22) tick();
        chk("t3_drop", 64'(drop_cnt), 64'd4);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_valid", 64'(out_valid), 64'd1);
        pops.delete();
        out_ready = 1'b1;
        repeat (18) tick();
        out_ready = 1'b0;
        chk("t3_drained", 64'(pops.size()), 64'd16);
        for (int i = 0; i < 16; i++) chk("t3_order", 64'(pops[i][32:17]), 64'(i + 1));

        // T5: re-arm from DONE clears drops; zero-length capture
        chk("t5_empty", 64'(out_valid), 64'd0);
        cap_len = 8'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("t5_armed", 64'(state), 64'd1);
        chk("t5_drop_clr", 64'(drop_cnt), 64'd0);
        tick();
        chk("t5_done", 64'(state), 64'd3);
        chk("t5_novalid", 64'(out_valid), 64'd0);
        tick();
        chk("t5_novalid2", 64'(out_valid), 64'd0);

        // T4: full FIFO with a ready sink during capture never drops
        do_reset();
        out_ready = 1'b0; cap_len = 8'd16; trig_x = 8'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (17) tick();
        chk("t4_full_done", 64'(state), 64'd3);
        chk("t4_full_drop", 64'(drop_cnt), 64'd0);
        cap_len = 8'd10;
        arm = 1'b1; tick(); arm = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        chk("t4_drop", 64'(drop_cnt), 64'd0);
        chk("t4_done", 64'(done), 64'd1);

        // T6: reset in the middle of a capture
        do_reset();
        out_ready = 1'b0; cap_len = 8'd10; trig_x = 8'd0;
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (5) tick();
        chk("t6_capture", 64'(state), 64'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_idle", 64'(state), 64'd0);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);
        cap_len = 8'd1; x = 8'd9; y = 8'd1; selector = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        exp_d = {16'd1, 1'b0, 8'd9, 8'd1};
        chk("t6_ts_restart", 64'(out_data), 64'(exp_d));

        // Random traffic against the model
        for (int n = 0; n < 1000; n++) begin
            selector  = 1'($urandom);
            x         = 8'($urandom);
            y         = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            arm       = ($urandom_range(0, 7) == 0);
            trig_x    = 8'($urandom_range(0, 255));
            cap_len   = 8'($urandom_range(0, 24));
            tick();
        end
        arm = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
